cic_decim_mc: RTL and testbench

CIC_DECIM_MC -- requirements
Module: cic_decim_mc

---
 rtl/cic_decim_mc_if.sv | 8 +
 rtl/cic_decim_mc.sv | 126 ++++++++++++
 tb/tb_cic_decim_mc.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/cic_decim_mc_if.sv
// cic_decim_mc_if: valid/ready stream carrying NUM_CH packed samples.
interface cic_decim_mc_if #(parameter int W = 32);
   logic valid;
   logic ready;
   logic [W-1:0] data;
   modport master (output valid, data, input ready);
   modport slave (input valid, data, output ready);
endinterface

// File: rtl/cic_decim_mc.sv
// cic_decim_mc: multichannel CIC decimator with runtime rate, rounded shift, saturation and sticky status.
module cic_decim_mc #(
   parameter int NUM_CH = 2,
   parameter int NUM_STAGES = 4,
   parameter int MAX_RATE = 256,
   parameter int DATA_WIDTH = 16,
   localparam int RATE_W = $clog2(MAX_RATE + 1),
   localparam int ACC_W = DATA_WIDTH + NUM_STAGES * $clog2(MAX_RATE),
   localparam int SHIFT_W = $clog2(ACC_W - DATA_WIDTH + 1)
) (
   input logic clk,
   input logic reset,
   input logic [RATE_W-1:0] rate,
   input logic [SHIFT_W-1:0] shift,
   input logic flush,
   input logic clr_status,
   cic_decim_mc_if.slave src,
   cic_decim_mc_if.master dst,
   output logic overrun,
   output logic sat
);
   localparam int GW = ACC_W - DATA_WIDTH;
   localparam logic signed [ACC_W:0] HI = {{(GW + 2){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
   localparam logic signed [ACC_W:0] LO = {{(GW + 2){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

   logic signed [ACC_W-1:0] integ [NUM_CH][NUM_STAGES];
   logic signed [ACC_W-1:0] inx [NUM_CH][NUM_STAGES];
   logic signed [ACC_W-1:0] pipe [NUM_CH][NUM_STAGES+1];
   logic signed [ACC_W-1:0] dly [NUM_CH][NUM_STAGES];
   logic signed [ACC_W-1:0] a;
   logic signed [ACC_W:0] t;
   logic [NUM_CH-1:0] clip;
   logic [NUM_CH*DATA_WIDTH-1:0] res, od;
   logic [NUM_STAGES:0] vld;
   logic [RATE_W-1:0] cnt, rq, rq_cur, rate_c;
   logic [SHIFT_W-1:0] s;
   logic rq_ld, acc, dec, hold, drop, ov;

   assign src.ready = !reset && !flush;
   assign acc = src.valid && src.ready;
   assign rate_c = rate < RATE_W'(2) ? RATE_W'(2) : rate > RATE_W'(MAX_RATE) ? RATE_W'(MAX_RATE) : rate;
   // rq_ld marks the first block after reset/flush, which takes its ratio straight from the input
   assign rq_cur = rq_ld ? rate_c : rq;
   assign dec = acc && cnt == rq_cur - 1'b1;
   assign s = shift > SHIFT_W'(GW) ? SHIFT_W'(GW) : shift;
   assign hold = ov && !dst.ready;
   assign drop = vld[NUM_STAGES] && hold;
   assign dst.valid = ov;
   assign dst.data = od;

   always_comb begin
      a = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         a = ACC_W'(signed'(src.data[c*DATA_WIDTH +: DATA_WIDTH]));
         for (int k = 0; k < NUM_STAGES; k++) begin
            a = integ[c][k] + a;
            inx[c][k] = a;
         end
      end
   end

   always_comb begin
      t = '0;
      clip = '0;
      res = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         t = {pipe[c][NUM_STAGES][ACC_W-1], pipe[c][NUM_STAGES]} + (((ACC_W + 1)'(1) << s) >> 1);
         t = t >>> s;
         clip[c] = t > HI || t < LO;
         res[c*DATA_WIDTH +: DATA_WIDTH] = t > HI ? HI[DATA_WIDTH-1:0] : t < LO ? LO[DATA_WIDTH-1:0] : t[DATA_WIDTH-1:0];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
         rq <= '0;
         rq_ld <= 1'b1;
         vld <= '0;
         ov <= 1'b0;
         od <= '0;
         integ <= '{default: '0};
         dly <= '{default: '0};
         pipe <= '{default: '0};
      end else if (flush) begin
         cnt <= '0;
         rq_ld <= 1'b1;
         vld <= '0;
         ov <= 1'b0;
         integ <= '{default: '0};
         dly <= '{default: '0};
         pipe <= '{default: '0};
      end else begin
         rq_ld <= 1'b0;
         if (rq_ld || dec) rq <= rate_c;
         if (acc) begin
            cnt <= dec ? '0 : cnt + 1'b1;
            integ <= inx;
         end
         vld <= {vld[NUM_STAGES-1:0], dec};
         for (int c = 0; c < NUM_CH; c++) begin
            if (dec) pipe[c][0] <= inx[c][NUM_STAGES-1];
            for (int k = 1; k <= NUM_STAGES; k++)
               if (vld[k-1]) begin
                  pipe[c][k] <= pipe[c][k-1] - dly[c][k-1];
                  dly[c][k-1] <= pipe[c][k-1];
               end
         end
         if (vld[NUM_STAGES] && !hold) begin
            ov <= 1'b1;
            od <= res;
         end else if (dst.ready) ov <= 1'b0;
      end
   end

   // a set event on the same edge as clr_status wins
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overrun <= 1'b0;
         sat <= 1'b0;
      end else begin
         overrun <= (drop && !flush) || (overrun && !clr_status);
         sat <= (vld[NUM_STAGES] && |clip && !flush) || (sat && !clr_status);
      end
   end
endmodule

// File: tb/tb_cic_decim_mc.sv
// tb_cic_decim_mc: directed and randomized checks of cic_decim_mc against a closed-form CIC model.
module tb_cic_decim_mc;
   localparam int N = 4;
   localparam int GW = 32;
   logic clk = 1'b0, reset = 1'b1, flush = 1'b0, clr_status = 1'b0, overrun, sat;
   logic [8:0] rate = 9'd16;
   logic [5:0] shift = 6'd16;
   logic [31:0] held;
   int total = 0, bad = 0;
   int nx, nd, m_cnt, m_rq;
   int rtab [6] = '{0, 1, 3, 5, 7, 257};
   longint xs [2][0:4095];
   longint ds [2][0:511];
   logic [31:0] exp_q[$], got_q[$];

   cic_decim_mc_if #(.W(32)) src();
   cic_decim_mc_if #(.W(32)) dst();

   cic_decim_mc #(.NUM_CH(2), .NUM_STAGES(N), .MAX_RATE(256), .DATA_WIDTH(16)) dut (
      .clk(clk), .reset(reset), .rate(rate), .shift(shift), .flush(flush),
      .clr_status(clr_status), .src(src), .dst(dst), .overrun(overrun), .sat(sat));

   always #5 clk = ~clk;

   always @(negedge clk) if (dst.valid && dst.ready) got_q.push_back(dst.data);

   function automatic int clampr(int r);
      return r < 2 ? 2 : r > 256 ? 256 : r;
   endfunction

   function automatic longint choose(int n, int k);
      longint r = 1;
      for (int i = 1; i <= k; i++) r = r * (n - k + i) / i;
      return r;
   endfunction

   function automatic logic [15:0] post(longint y, int sh);
      int se = sh > GW ? GW : sh;
      longint t = (y + (se > 0 ? (64'sd1 <<< (se - 1)) : 64'sd0)) >>> se;
      return t > 32767 ? 16'h7fff : t < -32768 ? 16'h8000 : t[15:0];
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic model_reset();
      nx = 0;
      nd = 0;
      m_cnt = 0;
      m_rq = clampr(int'(rate));
   endtask

   // Nth-order integration is a binomial-weighted sum; the comb chain is an Nth difference of the decimated sums
   task automatic model_beat(input logic [15:0] a, input logic [15:0] b);
      logic [15:0] o [2];
      longint y;
      xs[0][nx] = longint'($signed(a));
      xs[1][nx] = longint'($signed(b));
      nx++;
      if (m_cnt == m_rq - 1) begin
         for (int c = 0; c < 2; c++) begin
            longint d;
            d = 0;
            for (int i = 0; i < nx; i++) d += choose(nx - 1 - i + N - 1, N - 1) * xs[c][i];
            ds[c][nd] = d;
            y = 0;
            for (int j = 0; j <= N && j <= nd; j++) y += ((j % 2) ? -64'sd1 : 64'sd1) * choose(N, j) * ds[c][nd - j];
            o[c] = post(y, int'(shift));
         end
         nd++;
         exp_q.push_back({o[1], o[0]});
         m_cnt = 0;
         m_rq = clampr(int'(rate));
      end else m_cnt++;
   endtask

   task automatic beat(input logic [15:0] a, input logic [15:0] b, input int idle);
      repeat (idle) begin @(posedge clk); #1; end
      src.valid = 1'b1;
      src.data = {b, a};
      @(posedge clk); #1;
      src.valid = 1'b0;
      model_beat(a, b);
   endtask

   task automatic do_flush(input int r, input int s);
      rate = 9'(r);
      shift = 6'(s);
      flush = 1'b1;
      #1 chk("flush_in_ready", src.ready, 0);
      @(posedge clk); #1;
      flush = 1'b0;
      model_reset();
   endtask

   task automatic pulse_clr();
      clr_status = 1'b1;
      @(posedge clk); #1;
      clr_status = 1'b0;
   endtask

   task automatic drain_check(input string tag);
      repeat (N + 4) begin @(posedge clk); #1; end
      chk({tag, "_count"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         chk($sformatf("%s[%0d]", tag, i), got_q[i], exp_q[i]);
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      src.valid = 1'b0;
      src.data = '0;
      dst.ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", src.ready, 0);
      chk("rst_out_valid", dst.valid, 0);
      chk("rst_out_data", dst.data, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_sat", sat, 0);
      reset = 1'b0;
      model_reset();

      for (int i = 0; i < 128; i++) beat(16'd100, 16'd100, int'($urandom_range(0, 2)));
      repeat (N + 4) begin @(posedge clk); #1; end
      for (int i = 4; i < got_q.size(); i++) begin
         chk($sformatf("dc_ch0[%0d]", i), got_q[i][15:0], 100);
         chk($sformatf("dc_ch1[%0d]", i), got_q[i][31:16], 100);
      end
      chk("dc_sat", sat, 0);
      drain_check("dc");

      do_flush(2, 5);
      for (int i = 0; i < 16; i++) beat(16'd3, 16'hfffd, int'($urandom_range(0, 1)));
      repeat (N + 4) begin @(posedge clk); #1; end
      chk("round_ch0", got_q[got_q.size() - 1][15:0], 2);
      chk("round_ch1", got_q[got_q.size() - 1][31:16], 16'hffff);
      drain_check("round");

      do_flush(16, 12);
      for (int i = 0; i < 128; i++) beat(16'h7fff, 16'h8000, 0);
      repeat (N + 4) begin @(posedge clk); #1; end
      chk("sat_ch0", got_q[got_q.size() - 1][15:0], 16'h7fff);
      chk("sat_ch1", got_q[got_q.size() - 1][31:16], 16'h8000);
      chk("sat_set", sat, 1);
      drain_check("sat");
      chk("sat_sticky", sat, 1);
      pulse_clr();
      chk("sat_clr", sat, 0);

      do_flush(4, 12);
      for (int i = 0; i < 2; i++) beat(16'($urandom), 16'($urandom), 0);
      rate = 9'd8;
      for (int i = 0; i < 26; i++) beat(16'($urandom), 16'($urandom), int'($urandom_range(0, 1)));
      drain_check("ratechg");

      for (int r = 0; r < 6; r++) begin
         do_flush(rtab[r], int'($urandom_range(0, 40)));
         for (int i = 0; i < 6 * clampr(rtab[r]); i++) beat(16'($urandom), 16'($urandom), int'($urandom_range(0, 1)));
         drain_check($sformatf("rnd%0d", r));
      end

      pulse_clr();
      do_flush(4, 12);
      dst.ready = 1'b0;
      for (int i = 0; i < 4; i++) beat(16'($urandom), 16'($urandom), 0);
      for (int i = 0; i < 20 && !dst.valid; i++) begin @(posedge clk); #1; end
      chk("bp_valid", dst.valid, 1);
      chk("bp_first", dst.data, exp_q[0]);
      held = dst.data;
      for (int i = 0; i < 4; i++) beat(16'($urandom), 16'($urandom), 0);
      repeat (N + 3) begin @(posedge clk); #1; end
      chk("bp_held", dst.data, held);
      chk("bp_still_valid", dst.valid, 1);
      chk("bp_overrun", overrun, 1);
      exp_q.delete(1);
      dst.ready = 1'b1;
      drain_check("bp");
      chk("bp_gone", dst.valid, 0);
      pulse_clr();
      chk("bp_overrun_clr", overrun, 0);

      do_flush(4, 8);
      for (int i = 0; i < 2; i++) beat(16'($urandom), 16'($urandom), 0);
      #2 reset = 1'b1;
      #1 chk("mid_rst_in_ready", src.ready, 0);
      chk("mid_rst_out_valid", dst.valid, 0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      model_reset();
      for (int i = 0; i < 4; i++) beat(16'($urandom), 16'($urandom), 0);
      for (int i = 1; i <= N + 1; i++) begin
         @(posedge clk); #1;
         chk($sformatf("latency[%0d]", i), dst.valid, i == N + 1);
      end
      for (int i = 0; i < 4; i++) beat(16'($urandom), 16'($urandom), 0);
      drain_check("rst");

      for (int i = 0; i < 2; i++) beat(16'($urandom), 16'($urandom), 0);
      do_flush(4, 8);
      for (int i = 0; i < 8; i++) beat(16'($urandom), 16'($urandom), 0);
      drain_check("flush");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
